imem_loader: RTL

//  Writer side of the instruction-memory fetch path: receives a byte stream, packs it into

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory fetch path.
// Receives a framed byte stream (LEN lo, LEN hi, N little-endian words),
// packs the bytes into ISIZE-bit words and writes them to consecutive word
// addresses. The core is held in reset (cpu_hold) until the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to append an XOR checksum byte
// to the frame, checked in the CHK state before declaring the load good.
module imem_loader #(
    parameter int ISIZE  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ISIZE-1:0]  mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BPW   = ISIZE / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               byte_ready_q;
    logic               mem_wen_q;
    logic [ADDR_W-1:0]  mem_waddr_q;
    logic [ISIZE-1:0]   mem_wdata_q;
    logic               cpu_hold_q;
    logic               done_q;
    logic               error_q;
    logic [ADDR_W:0]    words_q;
    logic [7:0]         len_lo_q;
    logic [15:0]        len_q;
    logic [ISIZE-1:0]   shift_q;
    logic [BCW-1:0]     byte_cnt_q;
    logic [7:0]         chk_q;

    logic               accept;
    logic               start_take;
    logic [15:0]        len_n;
    logic               word_end;
    logic               last_word;
    logic [ISIZE-1:0]   word_next;

    assign accept     = byte_valid && byte_ready_q;
    assign start_take = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign len_n      = {byte_in, len_lo_q};
    assign word_end   = (byte_cnt_q == BCW'(BPW - 1));
    assign last_word  = (int'(words_q) + 1) == int'(len_q);
    // Newest byte enters at the top, so after BPW bytes the first one sits in [7:0].
    assign word_next  = (shift_q >> 8) | (ISIZE'(byte_in) << (ISIZE - 8));

    // Next-state decode of the load FSM.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN0;
            S_LEN0: if (accept) state_d = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if (int'(len_n) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && word_end && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) state_d = (byte_in == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous); all state uses <=.
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            chk_q        <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                            || (state_d == S_CHK)
`endif
                            ;
            mem_wen_q    <= 1'b0;
            // Status follows the state one cycle late, so the last write precedes cpu_hold=0.
            done_q       <= (state_q == S_DONE);
            error_q      <= (state_q == S_ERR);
            cpu_hold_q   <= (state_q != S_DONE);

            if (start_take) begin
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                cpu_hold_q <= 1'b1;
                words_q    <= '0;
                byte_cnt_q <= '0;
                chk_q      <= '0;
            end

            if (accept) begin
                chk_q <= chk_q ^ byte_in;
                case (state_q)
                    S_LEN0: len_lo_q <= byte_in;
                    S_LEN1: len_q    <= len_n;
                    S_DATA: begin
                        shift_q <= word_next;
                        if (word_end) begin
                            byte_cnt_q  <= '0;
                            mem_wen_q   <= 1'b1;
                            mem_waddr_q <= words_q[ADDR_W-1:0];
                            mem_wdata_q <= word_next;
                            words_q     <= words_q + 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_wen      = mem_wen_q;
    assign mem_waddr    = mem_waddr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
